// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard character path: PS/2 set-2 scancodes,
// the ASCII control characters produced, and the lower/upper case offset.
package kbd_pkg;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;

    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_CAPS  = 8'h58;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    function automatic logic is_lower(input logic [7:0] ch);
        return (ch >= ASCII_LOWER_A) && (ch <= ASCII_LOWER_Z);
    endfunction

endpackage

// File: rtl/kbd_scancode_rom.sv
// Combinational set-2 scancode to ASCII lookup; letters come out lowercase,
// caps lock is reported separately and never produces a character.
module kbd_scancode_rom
    import kbd_pkg::*;
(
    input  logic [7:0] scancode,
    output logic       hit,
    output logic       is_caps,
    output logic [7:0] ascii
);

    always_comb begin
        hit     = 1'b1;
        is_caps = 1'b0;
        ascii   = 8'h00;
        case (scancode)
            SC_A: ascii = 8'h61;
            SC_B: ascii = 8'h62;
            SC_C: ascii = 8'h63;
            SC_D: ascii = 8'h64;
            SC_E: ascii = 8'h65;
            SC_F: ascii = 8'h66;
            SC_G: ascii = 8'h67;
            SC_H: ascii = 8'h68;
            SC_I: ascii = 8'h69;
            SC_J: ascii = 8'h6A;
            SC_K: ascii = 8'h6B;
            SC_L: ascii = 8'h6C;
            SC_M: ascii = 8'h6D;
            SC_N: ascii = 8'h6E;
            SC_O: ascii = 8'h6F;
            SC_P: ascii = 8'h70;
            SC_Q: ascii = 8'h71;
            SC_R: ascii = 8'h72;
            SC_S: ascii = 8'h73;
            SC_T: ascii = 8'h74;
            SC_U: ascii = 8'h75;
            SC_V: ascii = 8'h76;
            SC_W: ascii = 8'h77;
            SC_X: ascii = 8'h78;
            SC_Y: ascii = 8'h79;
            SC_Z: ascii = 8'h7A;
            SC_0: ascii = 8'h30;
            SC_1: ascii = 8'h31;
            SC_2: ascii = 8'h32;
            SC_3: ascii = 8'h33;
            SC_4: ascii = 8'h34;
            SC_5: ascii = 8'h35;
            SC_6: ascii = 8'h36;
            SC_7: ascii = 8'h37;
            SC_8: ascii = 8'h38;
            SC_9: ascii = 8'h39;
            SC_SPACE: ascii = ASCII_SP;
            SC_ENTER: ascii = ASCII_CR;
            SC_BKSP:  ascii = ASCII_BS;
            SC_CAPS: begin
                hit     = 1'b0;
                is_caps = 1'b1;
            end
            // 8'h00 (no event) and every unmapped code land here
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/kbd_char_fifo.sv
// Keyboard release events -> ASCII (with caps lock) -> character FIFO drained
// by a valid/ready consumer. Two-stage pipeline: lookup register, then push.
module kbd_char_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    scancode,
    output logic [7:0]    char_data,
    output logic          char_valid,
    input  logic          char_ready,
    output logic          caps,
    output logic          overflow,
    input  logic          clr_overflow,
    output logic [AW:0]   fifo_count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    logic       rom_hit;
    logic       rom_is_caps;
    logic [7:0] rom_ascii;

    logic       s1_valid;
    logic [7:0] s1_char;
    logic       s1_caps_toggle;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic       full;
    logic       pop;
    logic       do_push;
    logic       drop;
    logic [7:0] push_char;

    kbd_scancode_rom u_rom (
        .scancode (scancode),
        .hit      (rom_hit),
        .is_caps  (rom_is_caps),
        .ascii    (rom_ascii)
    );

    // Pointer MSB separates full from empty when the index bits match
    assign fifo_count = wr_ptr - rd_ptr;
    assign char_valid = (fifo_count != '0);
    assign full       = (fifo_count == FULL_COUNT);
    assign pop        = char_valid && char_ready;
    assign do_push    = s1_valid && (!full || pop);
    assign drop       = s1_valid && full && !pop;

    // caps here is the pre-flip value; a toggle and a character never share a stage
    assign push_char = (caps && is_lower(s1_char)) ? (s1_char - CASE_OFFSET) : s1_char;

    assign char_data = char_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s1_char        <= 8'h00;
            s1_caps_toggle <= 1'b0;
            caps           <= 1'b0;
            overflow       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            s1_valid       <= rom_hit;
            s1_char        <= rom_ascii;
            s1_caps_toggle <= rom_is_caps;
            caps           <= caps ^ s1_caps_toggle;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (clr_overflow) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_char;
        end
    end

endmodule

// File: tb/tb_kbd_char_fifo.sv
// Bench for kbd_char_fifo: directed scenarios plus random traffic checked
// against a queue-based model of the translate/caps/FIFO behaviour.
module tb_kbd_char_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock;
    logic          reset;
    logic [7:0]    scancode;
    logic [7:0]    char_data;
    logic          char_valid;
    logic          char_ready;
    logic          caps;
    logic          overflow;
    logic          clr_overflow;
    logic [AW:0]   fifo_count;

    int tests_run;
    int tests_failed;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    logic [7:0] m_q [$];
    logic       m_caps;
    logic       m_ovf;
    logic [7:0] m_pend;

    kbd_char_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .scancode     (scancode),
        .char_data    (char_data),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .caps         (caps),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .fifo_count   (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void translate(input logic [7:0] sc, output logic hit,
                                      output logic capsk, output logic [7:0] ch);
        hit = 1'b0;
        capsk = 1'b0;
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (sc == letter_codes[i]) begin hit = 1'b1; ch = 8'h61 + 8'(i); end
        for (int i = 0; i < 10; i++)
            if (sc == digit_codes[i]) begin hit = 1'b1; ch = 8'h30 + 8'(i); end
        if (sc == 8'h29) begin hit = 1'b1; ch = 8'h20; end
        if (sc == 8'h5A) begin hit = 1'b1; ch = 8'h0D; end
        if (sc == 8'h66) begin hit = 1'b1; ch = 8'h08; end
        if (sc == 8'h58) capsk = 1'b1;
    endfunction

    // One clock: drive inputs, advance the model, then sample 1 time unit after the edge
    task automatic step(input logic [7:0] sc, input logic rdy, input logic clr);
        logic hit, capsk, m_pop, set_ovf;
        logic [7:0] ch;
        scancode = sc;
        char_ready = rdy;
        clr_overflow = clr;
        translate(m_pend, hit, capsk, ch);
        if (hit && m_caps && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
        m_pop = (m_q.size() > 0) && rdy;
        set_ovf = hit && (m_q.size() == DEPTH) && !m_pop;
        if (m_pop) void'(m_q.pop_front());
        if (hit && !set_ovf) m_q.push_back(ch);
        if (capsk) m_caps = !m_caps;
        m_ovf = clr ? 1'b0 : (m_ovf | set_ovf);
        m_pend = sc;
        @(posedge clock);
        #1;
        scancode = 8'h00;
        char_ready = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_caps = 1'b0;
        m_ovf = 1'b0;
        m_pend = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scancode = 8'h00;
        char_ready = 1'b0;
        clr_overflow = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", char_valid); end
        tests_run++;
        if (char_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", char_data); end
        tests_run++;
        if (caps !== 1'b0) begin tests_failed++; $display("FAIL reset_caps got %b want 0", caps); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
        tests_run++;
        if (fifo_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        step(8'h1C, 1'b0, 1'b0);
        tests_run++;
        if (char_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_latency1 got valid %b want 0", char_valid); end
        step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (char_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got %b want 1", char_valid); end
        tests_run++;
        if (char_data !== 8'h61) begin tests_failed++; $display("FAIL basic_data got %h want 61", char_data); end
        tests_run++;
        if (fifo_count !== 5'd1) begin tests_failed++; $display("FAIL basic_count got %0d want 1", fifo_count); end
        step(8'h00, 1'b1, 1'b0);
        tests_run++;
        if (char_valid !== 1'b0 || fifo_count !== 5'd0) begin
            tests_failed++; $display("FAIL basic_pop got valid %b count %0d want 0 0", char_valid, fifo_count);
        end
    endtask

    task automatic test_caps();
        step(8'h58, 1'b0, 1'b0);
        step(8'h1C, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (caps !== 1'b1) begin tests_failed++; $display("FAIL caps_on got %b want 1", caps); end
        tests_run++;
        if (char_data !== 8'h41) begin tests_failed++; $display("FAIL caps_upper got %h want 41", char_data); end
        step(8'h00, 1'b1, 1'b0);
        step(8'h58, 1'b0, 1'b0);
        step(8'h45, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (caps !== 1'b0) begin tests_failed++; $display("FAIL caps_off got %b want 0", caps); end
        tests_run++;
        if (char_data !== 8'h30) begin tests_failed++; $display("FAIL caps_digit got %h want 30", char_data); end
        step(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_ignored();
        step(8'hF0, 1'b0, 1'b0);
        step(8'h76, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (fifo_count !== 5'd0 || char_valid !== 1'b0) begin
            tests_failed++; $display("FAIL ignored_count got %0d valid %b want 0 0", fifo_count, char_valid);
        end
        tests_run++;
        if (caps !== 1'b0) begin tests_failed++; $display("FAIL ignored_caps got %b want 0", caps); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) step(8'h16, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (fifo_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_count got %0d want 16", fifo_count); end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
        tests_run++;
        if (char_data !== 8'h31) begin tests_failed++; $display("FAIL ovf_head got %h want 31", char_data); end
        step(8'h00, 1'b0, 1'b1);
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last;
        last = 8'h00;
        step(8'h29, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        tests_run++;
        if (fifo_count !== 5'd16) begin tests_failed++; $display("FAIL fullpp_count got %0d want 16", fifo_count); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpp_overflow got %b want 0", overflow); end
        for (int i = 0; i < 20; i++) begin
            if (char_valid) last = char_data;
            step(8'h00, 1'b1, 1'b0);
        end
        tests_run++;
        if (fifo_count !== 5'd0) begin tests_failed++; $display("FAIL fullpp_drain got %0d want 0", fifo_count); end
        tests_run++;
        if (last !== 8'h20) begin tests_failed++; $display("FAIL fullpp_last got %h want 20", last); end
    endtask

    task automatic test_mid_reset();
        step(8'h58, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(digit_codes[i], 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (fifo_count !== 5'd5 || caps !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_load got count %0d caps %b want 5 1", fifo_count, caps);
        end
        step(8'h24, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        tests_run++;
        if (char_valid !== 1'b0 || fifo_count !== 5'd0 || caps !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async got valid %b count %0d caps %b want 0 0 0", char_valid, fifo_count, caps);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
        tests_run++;
        if (char_valid !== 1'b0 || fifo_count !== 5'd0) begin
            tests_failed++; $display("FAIL midrst_after got valid %b count %0d want 0 0", char_valid, fifo_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] sc;
        logic [7:0] spec_codes [4] = '{8'h58, 8'h29, 8'h5A, 8'h66};
        logic rdy;
        int r;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom_range(0, 9);
            if (r < 4) sc = 8'h00;
            else if (r < 6) sc = letter_codes[$urandom_range(0, 25)];
            else if (r < 7) sc = digit_codes[$urandom_range(0, 9)];
            else if (r < 9) sc = spec_codes[$urandom_range(0, 3)];
            else sc = 8'($urandom_range(1, 255));
            rdy = ((cyc / 150) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            step(sc, rdy, $urandom_range(0, 19) == 0);
            tests_run++;
            if (fifo_count !== 5'(m_q.size()) || char_valid !== (m_q.size() > 0)
                || caps !== m_caps || overflow !== m_ovf
                || (m_q.size() > 0 && char_data !== m_q[0])) begin
                tests_failed++;
                $display("FAIL random_cycle%0d got cnt %0d val %b dat %h caps %b ovf %b want cnt %0d caps %b ovf %b head %h",
                         cyc, fifo_count, char_valid, char_data, caps, overflow,
                         m_q.size(), m_caps, m_ovf, (m_q.size() > 0) ? m_q[0] : 8'h00);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_caps();
        test_ignored();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/kbd_char_fifo.md
Name: kbd_char_fifo

Overview:
Sits directly downstream of the PS/2 keyboard handler. It consumes the handler's one-cycle key-release scancode pulses and translates PS/2 set-2 codes to ASCII, tracking caps-lock state. Translated characters are buffered in a FIFO. The FIFO is drained by the VGA text writer through a valid/ready handshake.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
AW, 4, FIFO address width; must equal log2(DEPTH).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
scancode  in  8  released-key scancode from the handler; non-zero for exactly one cycle per event, 8'h00 otherwise
char_data  out  8  ASCII character at the FIFO head
char_valid  out  1  FIFO non-empty; char_data is valid
char_ready  in  1  consumer accepts the head entry when char_valid and char_ready are both high
caps  out  1  caps-lock state (1 = uppercase)
overflow  out  1  sticky: a character was dropped because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow
fifo_count  out  AW+1  number of entries held, 0..DEPTH

Behaviour:
- Reset values: char_valid=0, char_data=8'h00, caps=0, overflow=0, fifo_count=0. Pointers and the stage-1 register are cleared. FIFO RAM contents are don't-care.
- Reset is asynchronous. Asserting it mid-operation flushes the FIFO and the in-flight stage-1 entry, and clears caps.
- Event definition: scancode != 8'h00 in a cycle. The block does not edge-detect; every non-zero cycle counts as one event.
- Stage 1, at the event edge: the combinational lookup output is registered as {s1_valid, s1_char, s1_caps_toggle}.
  - Letters a..z (set-2 codes 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A) map to 8'h61..8'h7A.
  - Digits 0..9 (45 16 1E 26 25 2E 36 3D 3E 46) map to 8'h30..8'h39.
  - 29 maps to 8'h20 (space), 5A to 8'h0D (enter), 66 to 8'h08 (backspace).
  - 58 (caps lock) sets s1_caps_toggle with s1_valid=0.
  - Every other code is dropped with no state change.
- Stage 2, the edge after stage 1:
  - If s1_caps_toggle is set, caps flips.
  - If s1_valid is set, the character is pushed. Letters are converted to uppercase (subtract 8'h20) when caps=1, using the caps value before any flip in the same cycle.
- Latency: event in cycle N produces char_valid high in cycle N+2 when the FIFO was empty.
- Consecutive events on back-to-back cycles are each accepted. The pipeline has no stall.
- Pop: occurs when char_valid && char_ready. The head advances at that edge. char_data is a combinational read of the head entry, stable while valid and not popped.
- Full (fifo_count==DEPTH):
  - A push with no pop in the same cycle is dropped and sets overflow.
  - A push and a pop in the same cycle are both performed; count is unchanged and overflow is not set.
- Empty: char_ready is ignored. A push and a pop cannot coincide when empty.
- Pointers are AW+1 bits, so full and empty are distinguished by the MSB; they wrap modulo 2*DEPTH.
- overflow: clr_overflow has priority over a new overflow set in the same cycle.
- fifo_count updates every edge by +1, -1 or 0.

Decomposition:
- Package kbd_pkg holds the set-2 scancode constants (SC_A..SC_Z, SC_0..SC_9, SC_SPACE=8'h29, SC_ENTER=8'h5A, SC_BKSP=8'h66, SC_CAPS=8'h58), the ASCII constants (ASCII_CR, ASCII_BS, ASCII_SP) and the case offset 8'h20.
- Sub-module kbd_scancode_rom is purely combinational. It takes scancode[7:0] and produces {hit, is_caps, ascii[7:0]}.
- The FIFO and the caps register live in the top module.

Test Plan:
- Reset, then a one-cycle pulse of 8'h1C: char_valid rises 2 cycles later with char_data=8'h61 and fifo_count=1. Pulse char_ready: valid drops and count returns to 0.
- Pulse 8'h58, then 8'h1C: caps=1 and char_data=8'h41. Pulse 8'h58 again, then 8'h45: caps=0 and char_data=8'h30.
- Pulse 8'hF0 and 8'h76: there is no push, fifo_count stays 0 and caps is unchanged.
- With char_ready=0, push 17 characters (8'h16 repeated): fifo_count=16 and overflow=1, and the head reads 8'h31. Assert clr_overflow: overflow clears.
- With the FIFO full and char_ready=1, push 8'h29 in the same cycle as a pop: count stays 16, overflow stays 0, and after draining the last entry read is 8'h20.
- Load 5 entries, assert reset mid-stream with a pulse in flight: char_valid=0, count=0 and caps=0 immediately, and nothing appears after reset is released.
